// File: rtl/line_overlay_sched.sv
// line_overlay_sched: schedules oblique-line overlays onto an XY raster scan.
//
// Two requesters hand in line descriptors over valid/ready; a round-robin
// arbiter loads a one-deep pending slot, which is promoted to the active line
// at each frame boundary. A 2-stage pipeline flags scanned pixels that lie on
// the active line.
//
// Ports:
//   iCLK, iRST        pixel clock, asynchronous active-high reset
//   iX_cnt, iY_cnt    current column/row from the XY counter
//   iValid[1:0]       per-requester descriptor valid
//   iDesc0, iDesc1    descriptors {x0[10:0], y0[9:0], x1[10:0], y1[9:0]}
//   oReady[1:0]       per-requester ready (combinational, at most one set)
//   iClear            drop the active line
//   oCommit           one-cycle pulse when pending becomes active
//   oActive           an active line exists
//   oPix_on           pixel presented two cycles earlier lies on the line
//   oPix_owner        requester id of the active line, qualified by oPix_on
module line_overlay_sched #(
    parameter int unsigned H_LINE = 20,
    parameter int unsigned V_LINE = 10
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [10:0] iX_cnt,
    input  logic [9:0]  iY_cnt,
    input  logic [1:0]  iValid,
    input  logic [41:0] iDesc0,
    input  logic [41:0] iDesc1,
    output logic [1:0]  oReady,
    input  logic        iClear,
    output logic        oCommit,
    output logic        oActive,
    output logic        oPix_on,
    output logic        oPix_owner
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned PW = 23;   // dy*ex / dx*ey product width
    localparam int unsigned EW = 24;   // p1 - p2 error width

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
    } desc_t;

    // Control registers
    desc_t pend_q, pend_d;
    desc_t act_q, act_d;
    logic  pend_v_q, pend_v_d;
    logic  pend_own_q, pend_own_d;
    logic  act_v_q, act_v_d;
    logic  act_own_q, act_own_d;
    logic  last_q, last_d;
    logic  commit_q, commit_d;

    // Pipeline registers
    logic signed [PW-1:0] p1_q, p1_d;
    logic signed [PW-1:0] p2_q, p2_d;
    logic                 bbox_q, bbox_d;
    logic [XW-1:0]        thr_q, thr_d;
    logic                 v1_q, v1_d;
    logic                 own1_q, own1_d;
    logic                 pix_on_q, pix_on_d;
    logic                 pix_owner_q, pix_owner_d;

    logic [1:0] grant;
    logic       other;
    logic       accept;
    logic       acc_id;
    logic       frame_end;
    logic       commit;

    // Round-robin grant: the requester that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        other = ~last_q;
        if (!pend_v_q) begin
            if (iValid[other]) begin
                grant[other] = 1'b1;
            end else if (iValid[last_q]) begin
                grant[last_q] = 1'b1;
            end
        end
    end

    assign oReady = iRST ? 2'b00 : grant;

    // Pending/active slot management.
    always_comb begin
        accept     = |(iValid & oReady);
        acc_id     = oReady[1];
        frame_end  = (iX_cnt == XW'(H_LINE - 1)) && (iY_cnt == YW'(V_LINE - 1));
        commit     = frame_end & pend_v_q;

        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        pend_own_d = pend_own_q;
        act_d      = act_q;
        act_v_d    = act_v_q;
        act_own_d  = act_own_q;
        last_d     = last_q;
        commit_d   = commit;

        // A commit takes precedence over a coincident clear.
        if (commit) begin
            act_d     = pend_q;
            act_v_d   = 1'b1;
            act_own_d = pend_own_q;
            pend_v_d  = 1'b0;
        end else if (iClear) begin
            act_v_d = 1'b0;
        end

        // Accept only happens with pending empty, so it never collides with commit.
        if (accept) begin
            pend_d     = acc_id ? desc_t'(iDesc1) : desc_t'(iDesc0);
            pend_v_d   = 1'b1;
            pend_own_d = acc_id;
            last_d     = acc_id;
        end
    end

    // Stage 1: cross products of the line direction and the pixel offset.
    logic signed [XW:0]   dx, ex;
    logic signed [YW:0]   dy, ey;
    logic [XW:0]          adx, amax;
    logic [YW:0]          ady;
    logic [XW-1:0]        xlo, xhi;
    logic [YW-1:0]        ylo, yhi;

    always_comb begin
        dx = $signed({1'b0, act_q.x1}) - $signed({1'b0, act_q.x0});
        dy = $signed({1'b0, act_q.y1}) - $signed({1'b0, act_q.y0});
        ex = $signed({1'b0, iX_cnt})   - $signed({1'b0, act_q.x0});
        ey = $signed({1'b0, iY_cnt})   - $signed({1'b0, act_q.y0});

        p1_d = $signed({{(PW-YW-1){dy[YW]}}, dy}) * $signed({{(PW-XW-1){ex[XW]}}, ex});
        p2_d = $signed({{(PW-XW-1){dx[XW]}}, dx}) * $signed({{(PW-YW-1){ey[YW]}}, ey});

        adx  = dx[XW] ? -dx : dx;
        ady  = dy[YW] ? -dy : dy;
        amax = (adx > {1'b0, ady}) ? adx : {1'b0, ady};
        thr_d = XW'(amax >> 1);

        xlo = (act_q.x0 < act_q.x1) ? act_q.x0 : act_q.x1;
        xhi = (act_q.x0 < act_q.x1) ? act_q.x1 : act_q.x0;
        ylo = (act_q.y0 < act_q.y1) ? act_q.y0 : act_q.y1;
        yhi = (act_q.y0 < act_q.y1) ? act_q.y1 : act_q.y0;
        bbox_d = (iX_cnt >= xlo) && (iX_cnt <= xhi) && (iY_cnt >= ylo) && (iY_cnt <= yhi);

        v1_d   = act_v_q;
        own1_d = act_own_q;
    end

    // Stage 2: the pixel is on the line when the cross-product error is within thr.
    logic signed [EW-1:0] err;
    logic [EW-1:0]        aerr;

    always_comb begin
        err         = $signed({p1_q[PW-1], p1_q}) - $signed({p2_q[PW-1], p2_q});
        aerr        = err[EW-1] ? -err : err;
        pix_on_d    = v1_q & bbox_q & (aerr <= {{(EW-XW){1'b0}}, thr_q});
        pix_owner_d = pix_on_d & own1_q;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_own_q  <= 1'b0;
            act_q       <= '0;
            act_v_q     <= 1'b0;
            act_own_q   <= 1'b0;
            last_q      <= 1'b1;
            commit_q    <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            bbox_q      <= 1'b0;
            thr_q       <= '0;
            v1_q        <= 1'b0;
            own1_q      <= 1'b0;
            pix_on_q    <= 1'b0;
            pix_owner_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            pend_own_q  <= pend_own_d;
            act_q       <= act_d;
            act_v_q     <= act_v_d;
            act_own_q   <= act_own_d;
            last_q      <= last_d;
            commit_q    <= commit_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            bbox_q      <= bbox_d;
            thr_q       <= thr_d;
            v1_q        <= v1_d;
            own1_q      <= own1_d;
            pix_on_q    <= pix_on_d;
            pix_owner_q <= pix_owner_d;
        end
    end

    assign oCommit    = commit_q;
    assign oActive    = act_v_q;
    assign oPix_on    = pix_on_q;
    assign oPix_owner = pix_owner_q;

endmodule
